// File: rtl/iomem_arbiter_if.sv
// Single iomem-style bus: valid/ready handshake with byte strobes, address and data.
// The master modport issues transactions; the slave modport answers them.
interface iomem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/iomem_arbiter.sv
// Two-requester round-robin arbiter onto one shared iomem port (IDLE -> BUSY -> RESP).
// Optional BUSY watchdog enabled by defining IOMEM_ARBITER_TIMEOUT_EN.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  iomem_arbiter_if.slave  m0,
  iomem_arbiter_if.slave  m1,
  iomem_arbiter_if.master s,
  output logic [1:0]      grant,
  output logic            timeout_pulse
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        busy;

`ifdef IOMEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef IOMEM_ARBITER_TIMEOUT_EN
      cnt_q        <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef IOMEM_ARBITER_TIMEOUT_EN
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef IOMEM_ARBITER_TIMEOUT_EN
    cnt_d        = cnt_q;
    abort_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // last_grant_q names the requester served last; the other one wins a tie
        if (m0.valid && m1.valid) begin
          grant_d = last_grant_q ? 2'b01 : 2'b10;
          state_d = BUSY;
        end else if (m0.valid) begin
          grant_d = 2'b01;
          state_d = BUSY;
        end else if (m1.valid) begin
          grant_d = 2'b10;
          state_d = BUSY;
        end
`ifdef IOMEM_ARBITER_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      BUSY: begin
        if (s.ready) begin
          if (grant_q[1]) rdata1_d = s.rdata;
          else            rdata0_d = s.rdata;
          state_d = RESP;
        end
`ifdef IOMEM_ARBITER_TIMEOUT_EN
        // A slave answer in the limit cycle takes priority over the abort
        else if (cnt_q + 16'd1 == TIMEOUT_LIM) begin
          if (grant_q[1]) rdata1_d = ERR_RDATA;
          else            rdata0_d = ERR_RDATA;
          abort_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        last_grant_d = grant_q[1];
        grant_d      = 2'b00;
        state_d      = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == BUSY);
  assign s.valid = busy;
  assign s.wstrb = busy ? (grant_q[1] ? m1.wstrb : m0.wstrb) : 4'b0000;
  assign s.addr  = grant_q[1] ? m1.addr  : m0.addr;
  assign s.wdata = grant_q[1] ? m1.wdata : m0.wdata;

  assign m0.ready = (state_q == RESP) && grant_q[0];
  assign m1.ready = (state_q == RESP) && grant_q[1];
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;
  assign grant    = grant_q;

`ifdef IOMEM_ARBITER_TIMEOUT_EN
  assign timeout_pulse = abort_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule
